op_scoreboard: RTL and testbench

In-flight destination scoreboard for the decode/issue stage. For every integer, FPU and predicate register it tracks how many cycles remain until the pending write reaches a forwarding point. Its stall output holds issue while a source operand, or a destination, is still in flight. It is the producer-side counterpart of the EX-stage forwarding unit: the scoreboard only lets an instruction into EX once forwarding (EX/MEM/WB bypass) can supply every operand.

---
 rtl/op_scoreboard.sv | 124 ++++++++++++
 tb/tb_op_scoreboard.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/op_scoreboard.sv
// op_scoreboard: in-flight destination scoreboard for the decode/issue stage.
//
// Holds one countdown counter per register of the FPU, integer and predicate
// files. A counter is loaded with the producer latency when a writer issues.
// It then counts down to zero, which is the point where the EX/MEM/WB bypass
// can supply the value. Issue is held while any source operand is still
// counting. Issue is also held when a destination would finish earlier than
// the write already in flight (WAW).
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset; clears every counter
//   issue_valid  instruction present at issue
//   issue_rw     destination files written: [2] F, [1] I, [0] P
//   issue_z      destination register id
//   issue_lat    cycles until the result is forwardable (0 = not tracked)
//   src_y/src_x  source register ids
//   use_y/use_x  files read by src_y/src_x (same F/I/P bit order)
//   flush        pipeline flush; clears all tracking, wins over issue
//   stall        combinational: hold issue this cycle
//   busy_f/i/p   per-register pending flags (counter != 0)

module op_scoreboard #(
    parameter int unsigned LAT_W = 3,
    parameter int unsigned NREG  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    issue_valid,
    input  logic [2:0]              issue_rw,
    input  logic [$clog2(NREG)-1:0] issue_z,
    input  logic [LAT_W-1:0]        issue_lat,
    input  logic [$clog2(NREG)-1:0] src_y,
    input  logic [$clog2(NREG)-1:0] src_x,
    input  logic [2:0]              use_y,
    input  logic [2:0]              use_x,
    input  logic                    flush,
    output logic                    stall,
    output logic [NREG-1:0]         busy_f,
    output logic [NREG-1:0]         busy_i,
    output logic [NREG-1:0]         busy_p
);

    localparam int unsigned NFILE  = 3;
    localparam int unsigned ID_W   = $clog2(NREG);
    // Bit position of each register file inside issue_rw / use_y / use_x.
    localparam int unsigned FILE_F = 2;
    localparam int unsigned FILE_I = 1;
    localparam int unsigned FILE_P = 0;

    logic [LAT_W-1:0] cnt_q [NFILE][NREG];
    logic [LAT_W-1:0] cnt_d [NFILE][NREG];

    logic raw_hit;
    logic waw_hit;
    logic accept;

    // Hazard detection against the current (pre-edge) counters.
    always_comb begin
        raw_hit = 1'b0;
        waw_hit = 1'b0;
        for (int f = 0; f < NFILE; f++) begin
            if (use_y[f] && (cnt_q[f][src_y] != '0)) begin
                raw_hit = 1'b1;
            end
            if (use_x[f] && (cnt_q[f][src_x] != '0)) begin
                raw_hit = 1'b1;
            end
            // A new write that would become forwardable before the older
            // in-flight write would be overtaken by it; hold it instead.
            if (issue_rw[f] && (cnt_q[f][issue_z] > issue_lat)) begin
                waw_hit = 1'b1;
            end
        end
    end

    // Flush masks the stall so the front end can redirect freely.
    always_comb begin
        stall  = issue_valid & (raw_hit | waw_hit) & ~flush;
        accept = issue_valid & ~(raw_hit | waw_hit) & ~flush;
    end

    // Counter update: flush, then load on accept, then saturating decrement.
    always_comb begin
        for (int f = 0; f < NFILE; f++) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_d[f][r] = cnt_q[f][r];
                if (flush) begin
                    cnt_d[f][r] = '0;
                end else if (accept && issue_rw[f] && (issue_z == ID_W'(r))) begin
                    cnt_d[f][r] = issue_lat;
                end else if (cnt_q[f][r] != '0) begin
                    cnt_d[f][r] = cnt_q[f][r] - LAT_W'(1);
                end
            end
        end
    end

    // Counter state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int f = 0; f < NFILE; f++) begin
                for (int r = 0; r < NREG; r++) begin
                    cnt_q[f][r] <= '0;
                end
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Busy flags decode straight from the counter registers.
    always_comb begin
        busy_f = '0;
        busy_i = '0;
        busy_p = '0;
        for (int r = 0; r < NREG; r++) begin
            busy_f[r] = (cnt_q[FILE_F][r] != '0);
            busy_i[r] = (cnt_q[FILE_I][r] != '0);
            busy_p[r] = (cnt_q[FILE_P][r] != '0);
        end
    end

endmodule

// File: tb/tb_op_scoreboard.sv
// Testbench for op_scoreboard. The driver applies one input vector per cycle
// and queues the hand-computed expected stall/busy values. The monitor pops
// one entry each falling edge and compares it against the DUT.

module tb_op_scoreboard;

    localparam logic [2:0] FF = 3'b100;
    localparam logic [2:0] FI = 3'b010;
    localparam logic [2:0] FP = 3'b001;
    localparam logic [2:0] FN = 3'b000;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic [2:0]  issue_rw;
    logic [3:0]  issue_z;
    logic [2:0]  issue_lat;
    logic [3:0]  src_y;
    logic [3:0]  src_x;
    logic [2:0]  use_y;
    logic [2:0]  use_x;
    logic        flush;
    logic        stall;
    logic [15:0] busy_f;
    logic [15:0] busy_i;
    logic [15:0] busy_p;

    typedef struct {
        string       name;
        logic        st;
        logic [15:0] bf;
        logic [15:0] bi;
        logic [15:0] bp;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    op_scoreboard #(.LAT_W(3), .NREG(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_rw    (issue_rw),
        .issue_z     (issue_z),
        .issue_lat   (issue_lat),
        .src_y       (src_y),
        .src_x       (src_x),
        .use_y       (use_y),
        .use_x       (use_x),
        .flush       (flush),
        .stall       (stall),
        .busy_f      (busy_f),
        .busy_i      (busy_i),
        .busy_p      (busy_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare mid-cycle, away from the rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_vec++;
            if ({stall, busy_f, busy_i, busy_p} !== {e.st, e.bf, e.bi, e.bp}) begin
                n_miss++;
                $display("FAIL %s: got stall=%0b f=%h i=%h p=%h, want stall=%0b f=%h i=%h p=%h",
                         e.name, stall, busy_f, busy_i, busy_p, e.st, e.bf, e.bi, e.bp);
            end
        end
    end

    task automatic drive(input logic v, input logic [2:0] rw, input logic [3:0] z,
                         input logic [2:0] lat, input logic [2:0] uy, input logic [3:0] sy,
                         input logic [2:0] ux, input logic [3:0] sx, input logic fl);
        issue_valid = v;
        issue_rw    = rw;
        issue_z     = z;
        issue_lat   = lat;
        use_y       = uy;
        src_y       = sy;
        use_x       = ux;
        src_x       = sx;
        flush       = fl;
    endtask

    task automatic idle();
        drive(1'b0, FN, 4'd0, 3'd0, FN, 4'd0, FN, 4'd0, 1'b0);
    endtask

    // Queue the expectation for the current cycle, then advance one cycle.
    task automatic step(input string name, input logic st, input logic [15:0] bf,
                        input logic [15:0] bi, input logic [15:0] bp);
        exp_t e;
        e.name = name;
        e.st   = st;
        e.bf   = bf;
        e.bi   = bi;
        e.bp   = bp;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b1, FN, 4'd0, 3'd0, FI, 4'd5, FN, 4'd0, 1'b0);
        @(posedge clk);
        #1;
        step("in_reset", 1'b0, 16'h0, 16'h0, 16'h0);
        rst = 1'b0;
        step("after_reset", 1'b0, 16'h0, 16'h0, 16'h0);

        // RAW on r5, latency 2.
        drive(1'b1, FI, 4'd5, 3'd2, FN, 4'd0, FN, 4'd0, 1'b0);
        step("raw_issue", 1'b0, 16'h0, 16'h0, 16'h0);
        drive(1'b1, FN, 4'd0, 3'd0, FI, 4'd5, FN, 4'd0, 1'b0);
        step("raw_c1", 1'b1, 16'h0, 16'h0020, 16'h0);
        step("raw_c2", 1'b1, 16'h0, 16'h0020, 16'h0);
        step("raw_c3", 1'b0, 16'h0, 16'h0, 16'h0);

        // WAW on f4: lat 5 in flight, lat 2 stalls, lat 3 at cnt 3 accepted.
        drive(1'b1, FF, 4'd4, 3'd5, FN, 4'd0, FN, 4'd0, 1'b0);
        step("waw_issue", 1'b0, 16'h0, 16'h0, 16'h0);
        drive(1'b1, FF, 4'd4, 3'd2, FN, 4'd0, FN, 4'd0, 1'b0);
        step("waw_stall", 1'b1, 16'h0010, 16'h0, 16'h0);
        idle();
        step("waw_c2", 1'b0, 16'h0010, 16'h0, 16'h0);
        drive(1'b1, FF, 4'd4, 3'd3, FN, 4'd0, FN, 4'd0, 1'b0);
        step("waw_equal", 1'b0, 16'h0010, 16'h0, 16'h0);
        idle();
        step("waw_c4", 1'b0, 16'h0010, 16'h0, 16'h0);
        step("waw_c5", 1'b0, 16'h0010, 16'h0, 16'h0);
        step("waw_c6", 1'b0, 16'h0010, 16'h0, 16'h0);
        step("waw_c7", 1'b0, 16'h0, 16'h0, 16'h0);

        // Flush with p7 pending and a simultaneous, hazarding P-write.
        drive(1'b1, FP, 4'd7, 3'd4, FN, 4'd0, FN, 4'd0, 1'b0);
        step("fl_setup", 1'b0, 16'h0, 16'h0, 16'h0);
        drive(1'b1, FP, 4'd2, 3'd3, FP, 4'd7, FN, 4'd0, 1'b1);
        step("fl_flush", 1'b0, 16'h0, 16'h0, 16'h0080);
        drive(1'b1, FN, 4'd0, 3'd0, FP, 4'd2, FP, 4'd7, 1'b0);
        step("fl_after", 1'b0, 16'h0, 16'h0, 16'h0);

        // Multi-file write I+P to r9, latency 1.
        drive(1'b1, 3'b011, 4'd9, 3'd1, FN, 4'd0, FN, 4'd0, 1'b0);
        step("mf_issue", 1'b0, 16'h0, 16'h0, 16'h0);
        drive(1'b1, FN, 4'd0, 3'd0, FN, 4'd0, FP, 4'd9, 1'b0);
        step("mf_p_stall", 1'b1, 16'h0, 16'h0200, 16'h0200);
        step("mf_p_free", 1'b0, 16'h0, 16'h0, 16'h0);
        drive(1'b1, 3'b011, 4'd9, 3'd1, FN, 4'd0, FN, 4'd0, 1'b0);
        step("mf_issue2", 1'b0, 16'h0, 16'h0, 16'h0);
        drive(1'b1, FN, 4'd0, 3'd0, FN, 4'd0, FF, 4'd9, 1'b0);
        step("mf_f_nostall", 1'b0, 16'h0, 16'h0200, 16'h0200);
        idle();
        step("mf_done", 1'b0, 16'h0, 16'h0, 16'h0);

        // Latency 0 back-to-back self-dependency never stalls.
        drive(1'b1, FI, 4'd3, 3'd0, FI, 4'd3, FN, 4'd0, 1'b0);
        step("l0_a", 1'b0, 16'h0, 16'h0, 16'h0);
        step("l0_b", 1'b0, 16'h0, 16'h0, 16'h0);

        // r3 = r3 op x with latency 1: one bubble, then reload.
        drive(1'b1, FI, 4'd3, 3'd1, FI, 4'd3, FN, 4'd0, 1'b0);
        step("self_acc", 1'b0, 16'h0, 16'h0, 16'h0);
        step("self_stall", 1'b1, 16'h0, 16'h0008, 16'h0);
        step("self_acc2", 1'b0, 16'h0, 16'h0, 16'h0);
        idle();
        step("self_busy", 1'b0, 16'h0, 16'h0008, 16'h0);
        step("self_done", 1'b0, 16'h0, 16'h0, 16'h0);

        // Register 0 is tracked.
        drive(1'b1, FP, 4'd0, 3'd2, FN, 4'd0, FN, 4'd0, 1'b0);
        step("r0_issue", 1'b0, 16'h0, 16'h0, 16'h0);
        drive(1'b1, FN, 4'd0, 3'd0, FN, 4'd0, FP, 4'd0, 1'b0);
        step("r0_c1", 1'b1, 16'h0, 16'h0, 16'h0001);
        step("r0_c2", 1'b1, 16'h0, 16'h0, 16'h0001);
        step("r0_c3", 1'b0, 16'h0, 16'h0, 16'h0);

        // Maximum latency 7 on r15, then saturation at 0.
        drive(1'b1, FI, 4'd15, 3'd7, FN, 4'd0, FN, 4'd0, 1'b0);
        step("max_issue", 1'b0, 16'h0, 16'h0, 16'h0);
        idle();
        for (int k = 1; k <= 7; k++) begin
            step($sformatf("max_c%0d", k), 1'b0, 16'h0, 16'h8000, 16'h0);
        end
        step("max_c8", 1'b0, 16'h0, 16'h0, 16'h0);
        step("max_c9", 1'b0, 16'h0, 16'h0, 16'h0);

        // Asynchronous reset between edges while r1 is counting from 6.
        drive(1'b1, FI, 4'd1, 3'd6, FN, 4'd0, FN, 4'd0, 1'b0);
        step("ar_issue", 1'b0, 16'h0, 16'h0, 16'h0);
        idle();
        step("ar_busy", 1'b0, 16'h0, 16'h0002, 16'h0);
        begin
            exp_t e;
            e.name = "ar_async";
            e.st   = 1'b0;
            e.bf   = 16'h0;
            e.bi   = 16'h0;
            e.bp   = 16'h0;
            q.push_back(e);
            #1 rst = 1'b1;
            @(posedge clk);
            #1 rst = 1'b0;
        end
        drive(1'b1, FN, 4'd0, 3'd0, FI, 4'd1, FN, 4'd0, 1'b0);
        step("ar_after", 1'b0, 16'h0, 16'h0, 16'h0);
        idle();

        // Let the monitor drain the queue, bounded.
        for (int k = 0; k < 10; k++) begin
            if (q.size() == 0) break;
            @(posedge clk);
        end
        if (q.size() != 0) begin
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
            $fatal(1, "expectation queue did not drain");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
